// File: rtl/rwm_frame_ctrl.sv
// rwm_frame_ctrl: sequences clear/write/read passes of the RGB pixel memory with a done watchdog.
module rwm_frame_ctrl #(
    parameter int N          = 2,
    parameter int M          = 2,
    parameter int AUTO_CLEAR = 1,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_req,
    input  logic             gray_ready,
    input  logic             err_clr,
    input  logic             RWM_done,
    output logic             RWM_enable,
    output logic             rw,
    output logic             clear,
    output logic             cam_capture,
    output logic             gray_start,
    output logic             busy,
    output logic             frame_done,
    output logic             error,
    output logic [CNT_W-1:0] frame_count
);
    localparam int TMAX = (TIMEOUT > 3*N*M+2) ? TIMEOUT : 3*N*M+3;
    localparam int TW   = $clog2(TMAX+1);
    typedef enum logic [3:0] {
        IDLE, CLR_CMD, CLR_WAIT, WR_CMD, WR_WAIT, RD_ARM, RD_CMD, RD_WAIT, FIN, ERR
    } state_t;
    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic waiting, expired;
    assign waiting = state inside {CLR_WAIT, WR_WAIT, RD_WAIT};
    assign expired = timer == TW'(TIMEOUT-1);
    // done is tested before expiry so a simultaneous done wins
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = frame_req ? ((AUTO_CLEAR != 0) ? CLR_CMD : WR_CMD) : IDLE;
            CLR_CMD:  state_nx = CLR_WAIT;
            CLR_WAIT: state_nx = RWM_done ? WR_CMD : expired ? ERR : CLR_WAIT;
            WR_CMD:   state_nx = WR_WAIT;
            WR_WAIT:  state_nx = RWM_done ? RD_ARM : expired ? ERR : WR_WAIT;
            RD_ARM:   state_nx = gray_ready ? RD_CMD : RD_ARM;
            RD_CMD:   state_nx = RD_WAIT;
            RD_WAIT:  state_nx = RWM_done ? FIN : expired ? ERR : RD_WAIT;
            FIN:      state_nx = IDLE;
            ERR:      state_nx = err_clr ? IDLE : ERR;
            default:  state_nx = IDLE;
        endcase
        timer_nx = (waiting && state_nx == state) ? timer + TW'(1) : '0;
    end
    // outputs are decoded from the next state and registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            RWM_enable  <= 1'b0;
            rw          <= 1'b0;
            clear       <= 1'b0;
            cam_capture <= 1'b0;
            gray_start  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            RWM_enable  <= state_nx inside {CLR_CMD, WR_CMD, RD_CMD};
            rw          <= state_nx == WR_CMD;
            clear       <= state_nx == CLR_CMD;
            cam_capture <= state_nx inside {WR_CMD, WR_WAIT};
            gray_start  <= state_nx == RD_CMD;
            busy        <= state_nx != IDLE;
            frame_done  <= state_nx == FIN;
            error       <= state_nx == ERR;
            if (state_nx == FIN)
                frame_count <= frame_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rwm_frame_ctrl.sv
// tb_rwm_frame_ctrl: drives two controllers (auto-clear on/off) against a reactive memory and a timeline model.
module tb_rwm_frame_ctrl;
    localparam int TO = 32;
    localparam logic [7:0] EN = 8'h80, RW = 8'h40, CL = 8'h20, CAM = 8'h10,
                           GS = 8'h08, BSY = 8'h04, FD = 8'h02, ER = 8'h01;
    logic clk = 0, rst_n, fr, gr, ec, chk_on;
    int dc, dw, dr;
    int n_chk = 0, n_pass = 0;
    logic en_a[2], rw_a[2], cl_a[2], cam_a[2], gs_a[2], bsy_a[2], fd_a[2], er_a[2], done_a[2];
    logic [7:0] fc_a[2];
    int mode[2], k[2], lat[2];
    logic [7:0] ecnt[2];
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gm
        int mc;
        rwm_frame_ctrl #(.N(2), .M(2), .AUTO_CLEAR(g == 0 ? 1 : 0), .TIMEOUT(TO), .CNT_W(8)) u_dut (
            .clk(clk), .rst_n(rst_n), .frame_req(fr), .gray_ready(gr), .err_clr(ec),
            .RWM_done(done_a[g]), .RWM_enable(en_a[g]), .rw(rw_a[g]), .clear(cl_a[g]),
            .cam_capture(cam_a[g]), .gray_start(gs_a[g]), .busy(bsy_a[g]),
            .frame_done(fd_a[g]), .error(er_a[g]), .frame_count(fc_a[g])
        );
        // memory raises done on wait cycle d after a command; d = 0 means never
        always @(posedge clk or negedge rst_n)
            if (!rst_n) mc <= 0;
            else if (en_a[g]) mc <= cl_a[g] ? dc : rw_a[g] ? dw : dr;
            else if (mc != 0) mc <= mc - 1;
        assign done_a[g] = (mc == 1);
    end

    task automatic chk(input string nm, input int i, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, want %0h", nm, i, got, want);
    endtask

    function automatic bit tmo(int d); return d == 0 || d > TO; endfunction
    function automatic int wl(int d); return tmo(d) ? TO : d; endfunction
    function automatic int plen(int ac);
        return ac != 0 ? (tmo(dc) ? 1 + TO : 2 + dc + wl(dw)) : 1 + wl(dw);
    endfunction
    function automatic bit perr(int ac); return (ac != 0 && tmo(dc)) || tmo(dw); endfunction
    function automatic int rlen(); return 1 + wl(dr) + (tmo(dr) ? 0 : 1); endfunction
    // expected outputs at offset j within the capture timeline
    function automatic logic [7:0] pre_v(int ac, int j);
        int r = j;
        if (ac != 0) begin
            if (r == 1) return EN | CL | BSY;
            if (r <= 1 + wl(dc)) return BSY;
            r -= 1 + wl(dc);
        end
        return r == 1 ? (EN | RW | CAM | BSY) : (CAM | BSY);
    endfunction
    function automatic logic [7:0] rd_v(int j);
        return j == 1 ? (EN | GS | BSY) : j <= 1 + wl(dr) ? BSY : (FD | BSY);
    endfunction
    function automatic logic [7:0] cur_v(int i);
        case (mode[i])
            1: return pre_v(i == 0 ? 1 : 0, k[i]);
            2: return BSY;
            3: return rd_v(k[i]);
            4: return BSY | ER;
            default: return 8'h00;
        endcase
    endfunction

    // modes: 0 idle, 1 capture timeline, 2 waiting for grayscaler, 3 read timeline, 4 error
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mode[i] = 0; k[i] = 0; ecnt[i] = 0;
            end
            if (chk_on) begin
                chk("outs", i, {en_a[i], rw_a[i], cl_a[i], cam_a[i], gs_a[i], bsy_a[i], fd_a[i], er_a[i]}, cur_v(i));
                chk("count", i, fc_a[i], ecnt[i]);
            end
            if (rst_n) begin
                case (mode[i])
                    0: if (fr) begin mode[i] = 1; k[i] = 1; end
                    1: begin
                        k[i]++;
                        if (k[i] > plen(i == 0 ? 1 : 0)) begin mode[i] = perr(i == 0 ? 1 : 0) ? 4 : 2; k[i] = 0; end
                    end
                    2: if (gr) begin mode[i] = 3; k[i] = 1; end
                    3: begin
                        k[i]++;
                        if (k[i] > rlen()) begin mode[i] = tmo(dr) ? 4 : 0; k[i] = 0; end
                    end
                    4: if (ec) mode[i] = 0;
                    default: mode[i] = 0;
                endcase
                if ((cur_v(i) & FD) != 0) ecnt[i] = ecnt[i] + 8'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_fr();
        fr = 1;
        tick(1);
        fr = 0;
    endtask

    initial begin
        bit seen;
        rst_n = 0; fr = 0; gr = 1; ec = 0; dc = 1; dw = 12; dr = 12; chk_on = 0;
        mode = '{0, 0}; k = '{0, 0}; ecnt = '{0, 0};
        tick(2);
        chk_on = 1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, bsy_a[i], 0);
            chk("rst_en", i, en_a[i], 0);
            chk("rst_cnt", i, fc_a[i], 0);
        end
        rst_n = 1;
        tick(2);
        lat = '{0, 0};
        pulse_fr();
        for (int n = 1; n <= 200 && (lat[0] == 0 || lat[1] == 0); n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (fd_a[i] && lat[i] == 0) lat[i] = n;
        end
        chk("latency", 0, lat[0], 30);
        chk("latency", 1, lat[1], 28);
        tick(5);
        for (int i = 0; i < 2; i++) begin
            chk("f1_busy", i, bsy_a[i], 0);
            chk("f1_cnt", i, fc_a[i], 1);
        end
        gr = 0;
        pulse_fr();
        tick(70);
        for (int i = 0; i < 2; i++) begin
            chk("arm_busy", i, bsy_a[i], 1);
            chk("arm_err", i, er_a[i], 0);
        end
        gr = 1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rdcmd_gs", i, gs_a[i], 1);
            chk("rdcmd_en", i, en_a[i], 1);
            chk("rdcmd_rw", i, rw_a[i], 0);
        end
        tick(20);
        for (int i = 0; i < 2; i++) chk("f2_cnt", i, fc_a[i], 2);
        dw = TO;
        pulse_fr();
        tick(80);
        for (int i = 0; i < 2; i++) begin
            chk("edge_err", i, er_a[i], 0);
            chk("edge_cnt", i, fc_a[i], 3);
        end
        dw = 0;
        pulse_fr();
        tick(60);
        for (int i = 0; i < 2; i++) begin
            chk("to_err", i, er_a[i], 1);
            chk("to_cam", i, cam_a[i], 0);
            chk("to_busy", i, bsy_a[i], 1);
        end
        ec = 1;
        tick(1);
        ec = 0;
        for (int i = 0; i < 2; i++) begin
            chk("clr_err", i, er_a[i], 0);
            chk("clr_busy", i, bsy_a[i], 0);
            chk("clr_cnt", i, fc_a[i], 3);
        end
        dw = 12;
        pulse_fr();
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (gs_a[0]) seen = 1;
        end
        chk("gs_seen", 0, seen, 1);
        tick(1);
        pulse_fr();
        tick(40);
        for (int i = 0; i < 2; i++) begin
            chk("drop_cnt", i, fc_a[i], 4);
            chk("drop_busy", i, bsy_a[i], 0);
        end
        pulse_fr();
        tick(5);
        for (int i = 0; i < 2; i++) chk("pre_rst_cam", i, cam_a[i], 1);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_outs", i, {en_a[i], rw_a[i], cl_a[i], cam_a[i], gs_a[i], bsy_a[i], fd_a[i], er_a[i]}, 0);
            chk("arst_cnt", i, fc_a[i], 0);
        end
        tick(1);
        rst_n = 1;
        tick(2);
        dc = 1; dw = 1; dr = 1;
        for (int f = 0; f < 255; f++) begin
            pulse_fr();
            tick(9);
        end
        for (int i = 0; i < 2; i++) chk("cnt255", i, fc_a[i], 255);
        pulse_fr();
        tick(9);
        for (int i = 0; i < 2; i++) chk("cnt_wrap", i, fc_a[i], 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
